// File: rtl/mod_inv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mod_inv_pkg
// Description : Shared mode encodings and FSM state type for the inverter.
// Revision    : 1.0 - initial release
// ============================================================================
package mod_inv_pkg;

    localparam logic [1:0] c_mode_classic = 2'd0;
    localparam logic [1:0] c_mode_almost  = 2'd1;
    localparam logic [1:0] c_mode_mont    = 2'd2;
    localparam logic [1:0] c_mode_rsvd    = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CHECK   = 3'd1,
        S_ALMOST  = 3'd2,
        S_CORRECT = 3'd3,
        S_PHASE2  = 3'd4,
        S_DONE    = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mod_inv_if.sv
`default_nettype none
// ============================================================================
// Module      : mod_inv_if
// Description : Request/response bundle between a requester and the engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface mod_inv_if #(
    parameter int N  = 256,
    parameter int KW = $clog2(2*N+1)
) ();
    import mod_inv_pkg::*;

    logic          start_inv;
    logic [1:0]    mode;
    logic [N-1:0]  a;
    logic [N-1:0]  P;
    logic          busy;
    logic          done_inv;
    logic          err;
    logic [N-1:0]  result;
    logic [KW-1:0] k_out;

    modport master (
        output start_inv, mode, a, P,
        input  busy, done_inv, err, result, k_out
    );

    modport slave (
        input  start_inv, mode, a, P,
        output busy, done_inv, err, result, k_out
    );
endinterface
`default_nettype wire

// File: rtl/mod_inv_shift.sv
`default_nettype none
// ============================================================================
// Module      : mod_inv_shift
// Description : Combinational modular halve (x/2 mod p) or double (2x mod p).
// Revision    : 1.0 - initial release
// ============================================================================
module mod_inv_shift #(
    parameter int N = 256
) (
    input  logic         i_dbl,
    input  logic [N-1:0] i_x,
    input  logic [N-1:0] i_p,
    output logic [N-1:0] o_y
);
    import mod_inv_pkg::*;

    logic [N-1:0] w_half;
    logic [N-1:0] w_dbl;

    always_comb begin
        // x and p both odd: (x+p)/2 == floor(x/2) + floor(p/2) + 1, no carry bit needed
        w_half = i_x >> 1;
        if (i_x[0]) begin
            w_half = (i_x >> 1) + (i_p >> 1) + N'(1);
        end
        // the lost top bit of 2x means the true value already exceeds p
        w_dbl = i_x << 1;
        if (i_x[N-1] || (w_dbl >= i_p)) begin
            w_dbl = w_dbl - i_p;
        end
        o_y = i_dbl ? w_dbl : w_half;
    end
endmodule
`default_nettype wire

// File: rtl/mod_inv_engine.sv
`default_nettype none
// ============================================================================
// Module      : mod_inv_engine
// Description : Kaliski almost-inverse with classical / Montgomery correction.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_inv_engine #(
    parameter int N  = 256,
    parameter int KW = $clog2(2*N+1)
) (
    input  logic      clk,
    input  logic      reset,
    mod_inv_if.slave  bus
);
    import mod_inv_pkg::*;

    localparam logic [KW-1:0] c_two_n = KW'(2*N);
    localparam logic [N:0]    c_one   = 1;

    state_t        r_state;
    state_t        w_next;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_p;
    logic [1:0]    r_mode;
    logic [N:0]    r_u;
    logic [N:0]    r_v;
    logic [N:0]    r_r;
    logic [N:0]    r_s;
    logic [KW-1:0] r_k;
    logic [KW-1:0] r_cnt;
    logic          r_err;
    logic [N-1:0]  r_result;
    logic [KW-1:0] r_k_out;

    logic          w_bad;
    logic [N:0]    w_r_red;
    logic [N:0]    w_r_corr;
    logic [KW-1:0] w_n2;
    logic [N-1:0]  w_shift;
    logic          w_busy;
    logic          w_done;

    assign w_bad = (r_a == '0) || (r_a >= r_p) || !r_p[0] ||
                   (r_p <= N'(1)) || (r_mode == c_mode_rsvd);

    assign w_r_red  = (r_r >= {1'b0, r_p}) ? (r_r - {1'b0, r_p}) : r_r;
    assign w_r_corr = {1'b0, r_p} - w_r_red;

    always_comb begin
        w_n2 = '0;
        case (r_mode)
            c_mode_classic: w_n2 = r_k;
            c_mode_almost:  w_n2 = '0;
            c_mode_mont:    w_n2 = c_two_n - r_k;
            default:        w_n2 = '0;
        endcase
    end

    mod_inv_shift #(.N(N)) u_shift (
        .i_dbl (r_mode == c_mode_mont),
        .i_x   (r_r[N-1:0]),
        .i_p   (r_p),
        .o_y   (w_shift)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start_inv) w_next = S_CHECK;
            end
            S_CHECK: begin
                w_busy = 1'b1;
                w_next = w_bad ? S_DONE : S_ALMOST;
            end
            S_ALMOST: begin
                w_busy = 1'b1;
                if (r_v == '0) w_next = S_CORRECT;
            end
            S_CORRECT: begin
                w_busy = 1'b1;
                w_next = (w_n2 == '0) ? S_DONE : S_PHASE2;
            end
            S_PHASE2: begin
                w_busy = 1'b1;
                if (r_cnt == KW'(1)) w_next = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Output registers load only on the transition into DONE so they hold until the next result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a      <= '0;
            r_p      <= '0;
            r_mode   <= '0;
            r_u      <= '0;
            r_v      <= '0;
            r_r      <= '0;
            r_s      <= '0;
            r_k      <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_result <= '0;
            r_k_out  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start_inv) begin
                        r_a    <= bus.a;
                        r_p    <= bus.P;
                        r_mode <= bus.mode;
                    end
                end
                S_CHECK: begin
                    if (w_bad) begin
                        r_err    <= 1'b1;
                        r_result <= '0;
                        r_k_out  <= '0;
                    end else begin
                        r_u <= {1'b0, r_p};
                        r_v <= {1'b0, r_a};
                        r_r <= '0;
                        r_s <= c_one;
                        r_k <= '0;
                    end
                end
                S_ALMOST: begin
                    if (r_v != '0) begin
                        if (!r_u[0]) begin
                            r_u <= r_u >> 1;
                            r_s <= r_s << 1;
                        end else if (!r_v[0]) begin
                            r_v <= r_v >> 1;
                            r_r <= r_r << 1;
                        end else if (r_u > r_v) begin
                            r_u <= (r_u - r_v) >> 1;
                            r_r <= r_r + r_s;
                            r_s <= r_s << 1;
                        end else begin
                            r_v <= (r_v - r_u) >> 1;
                            r_s <= r_s + r_r;
                            r_r <= r_r << 1;
                        end
                        r_k <= r_k + KW'(1);
                    end
                end
                S_CORRECT: begin
                    r_r   <= w_r_corr;
                    r_cnt <= w_n2;
                    if (w_n2 == '0) begin
                        r_err    <= 1'b0;
                        r_result <= w_r_corr[N-1:0];
                        r_k_out  <= r_k;
                    end
                end
                S_PHASE2: begin
                    r_r   <= {1'b0, w_shift};
                    r_cnt <= r_cnt - KW'(1);
                    if (r_cnt == KW'(1)) begin
                        r_err    <= 1'b0;
                        r_result <= w_shift;
                        r_k_out  <= r_k;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy     = w_busy;
    assign bus.done_inv = w_done;
    assign bus.err      = r_err;
    assign bus.result   = r_result;
    assign bus.k_out    = r_k_out;
endmodule
`default_nettype wire

// File: tb/tb_mod_inv_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_inv_engine
// Description : Scoreboard bench for mod_inv_engine at N=8 and N=256.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_inv_engine;

    typedef struct {
        logic [7:0] res;
        logic [4:0] k;
        logic       err;
        int         lat;
        int         start;
    } exp_s_t;

    typedef struct {
        logic [255:0] a;
        logic [255:0] p;
        int           start;
    } exp_b_t;

    localparam logic [255:0] c_p_big = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [255:0] c_a_big = 256'd6854325554222215243052392924557410287123964824515306282021023372829163033700;

    logic clk;
    logic rst_s;
    logic rst_b;
    int   cyc;
    int   checks;
    int   failures;

    exp_s_t q_s[$];
    exp_b_t q_b[$];
    exp_s_t es;
    exp_b_t eb;
    logic [511:0] prod;

    mod_inv_if #(.N(8))   sif ();
    mod_inv_if #(.N(256)) bif ();

    mod_inv_engine #(.N(8))   dut_s (.clk(clk), .reset(rst_s), .bus(sif));
    mod_inv_engine #(.N(256)) dut_b (.clk(clk), .reset(rst_b), .bus(bif));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Small-DUT monitor: every done_inv must match the oldest pending expectation
    always @(negedge clk) begin
        if (sif.done_inv) begin
            if (q_s.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL s_unexpected_done actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                es = q_s.pop_front();
                chk("s_result", sif.result, es.res);
                chk("s_k_out", sif.k_out, es.k);
                chk("s_err", sif.err, es.err);
                chk("s_latency", cyc - es.start, es.lat);
                chk("s_busy_at_done", sif.busy, 0);
            end
        end
    end

    always @(negedge clk) begin
        if (bif.done_inv) begin
            if (q_b.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_unexpected_done actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                eb   = q_b.pop_front();
                prod = {256'd0, eb.a} * {256'd0, bif.result};
                prod = prod % {256'd0, eb.p};
                chk("b_inverse", prod[255:0], 1);
                chk("b_err", bif.err, 0);
                chk("b_k_range", (bif.k_out >= 10'd128) && (bif.k_out <= 10'd512), 1);
                chk("b_latency", cyc - eb.start, 4 + 2 * int'(bif.k_out));
            end
        end
    end

    task automatic issue_s(input logic [7:0] ia, input logic [7:0] ip, input logic [1:0] im,
                           input logic [7:0] er, input logic [4:0] ek, input logic ee,
                           input int el, input bit push);
        exp_s_t e;
        @(negedge clk);
        sif.start_inv = 1'b1;
        sif.a         = ia;
        sif.P         = ip;
        sif.mode      = im;
        e.res = er; e.k = ek; e.err = ee; e.lat = el; e.start = cyc;
        if (push) q_s.push_back(e);
        @(negedge clk);
        sif.start_inv = 1'b0;
        sif.a         = 8'hA5;
        sif.P         = 8'h5A;
        sif.mode      = 2'd3;
    endtask

    task automatic wait_done_s(input int bound);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sif.done_inv && n < bound);
        if (!sif.done_inv) begin
            checks++;
            failures++;
            $display("FAIL s_timeout actual=%0d required<%0d cycles", n, bound);
        end
    endtask

    task automatic run_s(input logic [7:0] ia, input logic [7:0] ip, input logic [1:0] im,
                         input logic [7:0] er, input logic [4:0] ek, input logic ee, input int el);
        issue_s(ia, ip, im, er, ek, ee, el, 1'b1);
        wait_done_s(100);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst_s = 1'b1;
        rst_b = 1'b1;
        sif.start_inv = 1'b0; sif.a = '0; sif.P = '0; sif.mode = '0;
        bif.start_inv = 1'b0; bif.a = '0; bif.P = '0; bif.mode = '0;
        repeat (3) @(negedge clk);
        chk("s_rst_busy", sif.busy, 0);
        chk("s_rst_done", sif.done_inv, 0);
        chk("s_rst_err", sif.err, 0);
        chk("s_rst_result", sif.result, 0);
        chk("s_rst_k_out", sif.k_out, 0);
        chk("b_rst_busy", bif.busy, 0);
        chk("b_rst_done", bif.done_inv, 0);
        chk("b_rst_result", bif.result, 0);
        rst_s = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);

        // legal requests in all three modes, issued back to back
        run_s(8'd4,  8'd13, 2'd1, 8'd3,  5'd6, 1'b0, 10);
        run_s(8'd4,  8'd13, 2'd0, 8'd10, 5'd6, 1'b0, 16);
        run_s(8'd10, 8'd13, 2'd2, 8'd12, 5'd7, 1'b0, 20);
        run_s(8'd10, 8'd13, 2'd1, 8'd5,  5'd7, 1'b0, 11);
        run_s(8'd10, 8'd13, 2'd0, 8'd4,  5'd7, 1'b0, 18);
        run_s(8'd1,  8'd13, 2'd0, 8'd1,  5'd4, 1'b0, 12);
        run_s(8'd12, 8'd13, 2'd1, 8'd1,  5'd6, 1'b0, 10);

        // illegal requests
        run_s(8'd0,  8'd13, 2'd0, 8'd0, 5'd0, 1'b1, 2);
        run_s(8'd13, 8'd13, 2'd1, 8'd0, 5'd0, 1'b1, 2);
        run_s(8'd4,  8'd12, 2'd0, 8'd0, 5'd0, 1'b1, 2);
        run_s(8'd4,  8'd13, 2'd3, 8'd0, 5'd0, 1'b1, 2);
        run_s(8'd3,  8'd1,  2'd0, 8'd0, 5'd0, 1'b1, 2);

        // a start pulse while busy must not disturb the running operation
        issue_s(8'd4, 8'd13, 2'd0, 8'd10, 5'd6, 1'b0, 16, 1'b1);
        repeat (2) @(negedge clk);
        sif.start_inv = 1'b1; sif.a = 8'd1; sif.P = 8'd13; sif.mode = 2'd1;
        @(negedge clk);
        sif.start_inv = 1'b0;
        wait_done_s(100);

        // abort by reset in the 5th busy cycle
        issue_s(8'd4, 8'd13, 2'd0, 8'd10, 5'd6, 1'b0, 16, 1'b0);
        repeat (4) @(negedge clk);
        chk("s_busy_5th", sif.busy, 1);
        rst_s = 1'b1;
        #1;
        chk("s_abort_busy", sif.busy, 0);
        chk("s_abort_done", sif.done_inv, 0);
        chk("s_abort_err", sif.err, 0);
        chk("s_abort_result", sif.result, 0);
        chk("s_abort_k_out", sif.k_out, 0);
        repeat (3) @(negedge clk);
        rst_s = 1'b0;
        repeat (20) @(negedge clk);
        run_s(8'd4, 8'd13, 2'd0, 8'd10, 5'd6, 1'b0, 16);

        // N=256 classical inverse, with an ignored second start
        @(negedge clk);
        bif.start_inv = 1'b1;
        bif.a         = c_a_big;
        bif.P         = c_p_big;
        bif.mode      = 2'd0;
        eb.a = c_a_big; eb.p = c_p_big; eb.start = cyc;
        q_b.push_back(eb);
        @(negedge clk);
        bif.start_inv = 1'b0;
        bif.a         = 256'd5;
        repeat (3) @(negedge clk);
        bif.start_inv = 1'b1;
        bif.mode      = 2'd1;
        @(negedge clk);
        bif.start_inv = 1'b0;
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bif.done_inv && n < 1500);
            if (!bif.done_inv) begin
                checks++;
                failures++;
                $display("FAIL b_timeout actual=%0d required<1500 cycles", n);
            end
        end
        repeat (20) @(negedge clk);

        chk("s_scoreboard_empty", q_s.size(), 0);
        chk("b_scoreboard_empty", q_b.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
